// File: rtl/psc_trigger_conditioner.sv
// psc_trigger_conditioner: synchronises, glitch-filters and edge-qualifies the
// raw external PSC trigger, then issues a single-cycle trigger_pulse followed by
// a holdoff window that shields the downstream psc_trigger_fsm frames.
module psc_trigger_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 4,
  parameter int HOLDOFF_CYCLES = 20,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger_in,
  input  logic                 enable,
  input  logic                 clear_counts,
  output logic                 trigger_pulse,
  output logic                 armed,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] trigger_count,
  output logic [CNT_WIDTH-1:0] missed_count,
  output logic [CNT_WIDTH-1:0] glitch_count
);

  localparam int QW = $clog2(FILTER_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {ARM, IDLE, QUAL, FIRE, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_in;
  logic                   sync_prev;
  logic                   rise;
  logic [QW-1:0]          qual_cnt;
  logic [HW-1:0]          hold_cnt;
  logic                   glitch_inc;
  logic                   missed_inc;
  logic                   trig_inc;

  assign sync_in = sync_ff[SYNC_STAGES-1];
  assign rise    = sync_in & ~sync_prev;

  // Event strobes feeding the status counters, decoded from the current state.
  assign glitch_inc = (state == QUAL) && enable && !sync_in;
  assign missed_inc = rise && ((state == FIRE) || (state == HOLD));
  assign trig_inc   = (state == FIRE);

  // Synchroniser chain plus one-cycle delayed copy for rise detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff   <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], trigger_in};
      sync_prev <= sync_in;
    end
  end

  // Trigger FSM with registered pulse/armed/busy; ARM blocks level-held inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ARM;
      qual_cnt      <= '0;
      hold_cnt      <= '0;
      trigger_pulse <= 1'b0;
      armed         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      trigger_pulse <= 1'b0;
      case (state)
        ARM: begin
          if (enable && !sync_in) begin
            state <= IDLE;
            armed <= 1'b1;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (!enable) begin
            state <= ARM;
            armed <= 1'b0;
            busy  <= 1'b0;
          end else if (sync_in) begin
            armed    <= 1'b0;
            busy     <= 1'b1;
            qual_cnt <= QW'(1);
            if (FILTER_CYCLES == 1) begin
              state         <= FIRE;
              trigger_pulse <= 1'b1;
            end else begin
              state <= QUAL;
            end
          end
        end
        QUAL: begin
          if (!enable) begin
            state <= ARM;
            armed <= 1'b0;
            busy  <= 1'b0;
          end else if (!sync_in) begin
            state <= IDLE;
            armed <= 1'b1;
            busy  <= 1'b0;
          end else if (qual_cnt == QW'(FILTER_CYCLES - 1)) begin
            state         <= FIRE;
            trigger_pulse <= 1'b1;
          end else begin
            qual_cnt <= qual_cnt + QW'(1);
          end
        end
        FIRE: begin
          state    <= HOLD;
          hold_cnt <= HW'(HOLDOFF_CYCLES);
        end
        HOLD: begin
          if (hold_cnt == HW'(1)) begin
            state <= ARM;
            busy  <= 1'b0;
            armed <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state <= ARM;
          armed <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Status counters; clear overrides any coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trigger_count <= '0;
      missed_count  <= '0;
      glitch_count  <= '0;
    end else if (clear_counts) begin
      trigger_count <= '0;
      missed_count  <= '0;
      glitch_count  <= '0;
    end else begin
      if (trig_inc)
        trigger_count <= trigger_count + CNT_ONE;
      if (missed_inc && (missed_count != '1))
        missed_count <= missed_count + CNT_ONE;
      if (glitch_inc && (glitch_count != '1))
        glitch_count <= glitch_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_psc_trigger_conditioner.sv
// Directed bench for psc_trigger_conditioner (4-bit counters so saturation is reachable).
module tb_psc_trigger_conditioner;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          trigger_in;
  logic          enable;
  logic          clear_counts;
  logic          trigger_pulse;
  logic          armed;
  logic          busy;
  logic [CW-1:0] trigger_count;
  logic [CW-1:0] missed_count;
  logic [CW-1:0] glitch_count;

  psc_trigger_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(4), .HOLDOFF_CYCLES(20), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .trigger_in(trigger_in), .enable(enable),
    .clear_counts(clear_counts), .trigger_pulse(trigger_pulse), .armed(armed),
    .busy(busy), .trigger_count(trigger_count), .missed_count(missed_count),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic trig;
    logic pulse;
    logic armed;
    logic busy;
  } vec_t;

  vec_t tv [34];

  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  int   consec = 0;
  logic prev_pulse = 1'b0;
  int   exp_pulses = 0;
  int   exp_trig = 0;
  int   exp_missed = 0;
  int   exp_glitch = 0;
  int   busy_n;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later; tracks pulse statistics.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (trigger_pulse) begin
      if (prev_pulse) consec++;
      pulses++;
    end
    prev_pulse = trigger_pulse;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_trigger_count"}, int'(trigger_count), exp_trig);
    chk({tag, "_missed_count"},  int'(missed_count),  exp_missed);
    chk({tag, "_glitch_count"},  int'(glitch_count),  exp_glitch);
  endtask

  task automatic wait_pulse(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (trigger_pulse) break;
      cyc();
    end
    chk({tag, "_pulse_seen"}, int'(trigger_pulse), 1);
  endtask

  // Qualified trigger, then toggles during HOLD, each producing one rise.
  task automatic round(input int toggles);
    trigger_in = 1'b1;
    repeat (6) cyc();
    for (int t = 0; t < toggles; t++) begin
      trigger_in = 1'b0; cyc(); cyc();
      trigger_in = 1'b1; cyc(); cyc();
    end
    trigger_in = 1'b0;
    repeat (26) cyc();
  endtask

  initial begin
    reset = 1'b1; trigger_in = 1'b0; enable = 1'b1; clear_counts = 1'b0;

    // Reset state
    #12;
    chk("rst_pulse", int'(trigger_pulse), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_busy",  int'(busy), 0);
    chk_counts("rst");
    @(negedge clk) reset = 1'b0;
    cyc(); cyc();
    chk("boot_armed", int'(armed), 1);

    // 1: held-high trigger, cycle-by-cycle vectors (index = edge number)
    for (int i = 0; i < 34; i++) begin
      tv[i].trig  = (i < 30);
      tv[i].pulse = (i == 5);
      tv[i].busy  = (i >= 2) && (i <= 25);
      tv[i].armed = (i <= 1) || (i >= 32);
    end
    for (int i = 0; i < 34; i++) begin
      trigger_in = tv[i].trig;
      cyc();
      chk($sformatf("t1_pulse[%0d]", i), int'(trigger_pulse), int'(tv[i].pulse));
      chk($sformatf("t1_armed[%0d]", i), int'(armed), int'(tv[i].armed));
      chk($sformatf("t1_busy[%0d]", i),  int'(busy), int'(tv[i].busy));
    end
    exp_pulses = 1; exp_trig = 1;
    chk("t1_pulses", pulses, exp_pulses);
    chk_counts("t1");

    // 2: short high -> glitch
    trigger_in = 1'b1; cyc(); cyc();
    trigger_in = 1'b0; repeat (8) cyc();
    exp_glitch = 1;
    chk("t2_pulses", pulses, exp_pulses);
    chk("t2_armed", int'(armed), 1);
    chk_counts("t2");

    // 3: second trigger during HOLD is missed, later one fires
    trigger_in = 1'b1; repeat (6) cyc();
    trigger_in = 1'b0; repeat (4) cyc();
    trigger_in = 1'b1; repeat (6) cyc();
    trigger_in = 1'b0; repeat (20) cyc();
    exp_pulses = 2; exp_trig = 2; exp_missed = 1;
    chk("t3_pulses_a", pulses, exp_pulses);
    chk("t3_armed", int'(armed), 1);
    chk_counts("t3a");
    trigger_in = 1'b1; repeat (8) cyc();
    trigger_in = 1'b0; repeat (30) cyc();
    exp_pulses = 3; exp_trig = 3;
    chk("t3_pulses_b", pulses, exp_pulses);
    chk_counts("t3b");

    // 4: missed_count saturation, then clear vs coincident increment
    for (int r = 0; r < 5; r++) begin
      round(4);
      exp_pulses++;
      exp_trig   = (exp_trig + 1) % 16;
      exp_missed = (exp_missed + 4 > 15) ? 15 : exp_missed + 4;
      chk_counts($sformatf("t4_r%0d", r));
    end
    chk("t4_pulses", pulses, exp_pulses);
    trigger_in = 1'b1;
    wait_pulse("t4_clr");
    clear_counts = 1'b1; cyc(); clear_counts = 1'b0;
    exp_pulses++; exp_trig = 0; exp_missed = 0; exp_glitch = 0;
    chk_counts("t4_clr");
    trigger_in = 1'b0; repeat (30) cyc();
    chk_counts("t4_after");

    // 5a: enable dropped in QUAL
    trigger_in = 1'b1; repeat (3) cyc();
    enable = 1'b0; cyc();
    chk("t5_qual_armed", int'(armed), 0);
    chk("t5_qual_busy",  int'(busy), 0);
    trigger_in = 1'b0; repeat (10) cyc();
    chk("t5_qual_pulses", pulses, exp_pulses);
    chk("t5_qual_armed2", int'(armed), 0);
    chk_counts("t5a");
    enable = 1'b1; cyc(); cyc();
    chk("t5_rearm", int'(armed), 1);

    // 5b: enable dropped in HOLD; HOLD still runs to completion
    trigger_in = 1'b1; repeat (8) cyc();
    enable = 1'b0; trigger_in = 1'b0;
    busy_n = 0;
    repeat (25) begin cyc(); if (busy) busy_n++; end
    exp_pulses++; exp_trig++;
    chk("t5_hold_busy_cycles", busy_n, 18);
    chk("t5_hold_armed", int'(armed), 0);
    chk("t5_hold_busy",  int'(busy), 0);
    chk("t5_hold_pulses", pulses, exp_pulses);
    chk_counts("t5b");
    enable = 1'b1; cyc(); cyc();
    chk("t5_hold_rearm", int'(armed), 1);

    // 6: async reset in FIRE
    trigger_in = 1'b1;
    wait_pulse("t6");
    exp_pulses++;
    #2 reset = 1'b1;
    #1;
    exp_trig = 0; exp_missed = 0; exp_glitch = 0;
    chk("t6_pulse", int'(trigger_pulse), 0);
    chk("t6_armed", int'(armed), 0);
    chk("t6_busy",  int'(busy), 0);
    chk_counts("t6");
    trigger_in = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    prev_pulse = 1'b0;
    cyc(); cyc();
    chk("t6_armed_after", int'(armed), 1);
    chk("t6_total_pulses", pulses, exp_pulses);
    chk("no_consecutive_pulses", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
